i2c_write_sequencer: RTL and testbench
======================================

I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

Interface
REQ-001 Parameter SEQ_LEN, default 3, meaning total bytes per transaction including the address byte (range 2..15).
REQ-002 Parameter DEV_ADDR, default 7'h50, meaning the 7-bit slave address.
REQ-003 Parameter MAX_RETRY, default 3, meaning extra attempts after a NACK (used only with I2C_SEQ_RETRY_EN).
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port start_bar  in  1  active-low request (push button), asynchronous to clk.
REQ-007 Port payload  in  8*(SEQ_LEN-1)  data bytes; byte k (k>=1) is payload[8*(k-1)+:8].
REQ-008 Port cmd_valid  out  1  command to the I2C controller is valid.
REQ-009 Port cmd_ready  in  1  the I2C controller accepts the command.
REQ-010 Port cmd_data  out  8  byte to transmit.
REQ-011 Port cmd_start  out  1  issue START before this byte.
REQ-012 Port cmd_stop  out  1  issue STOP after this byte.
REQ-013 Port rsp_valid  in  1  one-cycle pulse: byte finished.
REQ-014 Port rsp_nack  in  1  qualifies rsp_valid: 1 = NACK, 0 = ACK.
REQ-015 Port busy  out  1  transaction in progress.
REQ-016 Port done  out  1  one-cycle completion pulse.
REQ-017 Port indicate_ack_received_bar  out  1  low = last transaction fully ACKed.
REQ-018 Port indicate_nack_received_bar  out  1  low = last transaction ended on NACK.
REQ-019 Port display  out  8  {attempt count[3:0], bytes ACKed in the final attempt[3:0]}.

Function
REQ-020 start_bar SHALL pass through a 2-flop synchroniser; a high-to-low transition of the synchronised signal SHALL form a start event.
REQ-021 A start event in IDLE SHALL capture payload, clear the byte index and attempt count, set busy, and enter ISSUE; cmd_valid SHALL be high after the 3rd rising edge following the first edge that samples start_bar low.
REQ-022 Start events outside IDLE SHALL be ignored.
REQ-023 States: IDLE, ISSUE, WAIT_RSP, FINISH.
REQ-024 ISSUE: cmd_valid=1; cmd_data={DEV_ADDR,1'b0} for index 0, otherwise the captured payload byte; cmd_start=(index==0); cmd_stop=(index==SEQ_LEN-1).
REQ-025 A command SHALL transfer on an edge with cmd_valid and cmd_ready both high; cmd_valid, cmd_data, cmd_start and cmd_stop SHALL stay stable until that edge; on transfer go to WAIT_RSP with cmd_valid low.
REQ-026 WAIT_RSP, rsp_valid with ACK: increment the ACK count; if index==SEQ_LEN-1 go to FINISH (success), else increment index and go to ISSUE.
REQ-027 WAIT_RSP, rsp_valid with NACK: go to FINISH (failure); the controller generates STOP after a NACK on its own, so this block issues no STOP command.
REQ-028 rsp_valid outside WAIT_RSP SHALL be ignored; rsp_valid on the same edge as a transfer SHALL be ignored.
REQ-029 FINISH lasts exactly one cycle: done=1, busy deasserts on exit, update the indicators (exactly one low), then go to IDLE.
REQ-030 The ACK count and attempt count SHALL saturate at 15.

Reset
REQ-031 On reset assertion, immediately: state IDLE, cmd_valid/cmd_start/cmd_stop/busy/done=0, cmd_data=0, both indicators=1, display=8'h00, synchroniser flops=1.
REQ-032 A reset in the middle of a transaction SHALL abandon it without a done pulse; a start_bar held low through reset release SHALL NOT create a start event.

Configuration
REQ-033 With macro I2C_SEQ_RETRY_EN defined, a NACK while attempt count <= MAX_RETRY SHALL increment the attempt count, clear index and ACK count, and go to ISSUE (restart with START), not FINISH.
REQ-034 Without I2C_SEQ_RETRY_EN, every NACK SHALL go to FINISH and the attempt count SHALL remain 1.

Verification
REQ-035 Defaults, payload=16'hA55A, all ACK -> cmd_data sequence A0(start), 5A, A5(stop); one done pulse; ack_bar=0; display=8'h13.
REQ-036 NACK on byte 1, retry disabled -> 2 transfers, done, nack_bar=0, ack_bar=1, display=8'h11.
REQ-037 I2C_SEQ_RETRY_EN, NACK on every address byte -> 4 attempts of A0 with start=1, then done, display=8'h40, nack_bar=0.
REQ-038 cmd_ready held low 10 cycles while in ISSUE -> cmd_valid/cmd_data stable all 10 cycles, single transfer.
REQ-039 Second start_bar pulse while busy, and reset asserted during WAIT_RSP -> no second transaction; reset outputs appear immediately, no done pulse.

Source files
------------

// File: rtl/i2c_write_sequencer.sv
// I2C write sequencer: on a synchronised start_bar press, issues START + address + payload bytes + STOP
// to a byte-level I2C controller. Optional NACK retry is enabled with macro I2C_SEQ_RETRY_EN.
module i2c_write_sequencer #(
    parameter int         SEQ_LEN   = 3,
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         MAX_RETRY = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_bar,
    input  logic [8*(SEQ_LEN-1)-1:0]   payload,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [7:0]                 cmd_data,
    output logic                       cmd_start,
    output logic                       cmd_stop,
    input  logic                       rsp_valid,
    input  logic                       rsp_nack,
    output logic                       busy,
    output logic                       done,
    output logic                       indicate_ack_received_bar,
    output logic                       indicate_nack_received_bar,
    output logic [7:0]                 display
);

    // state    | meaning
    // IDLE     | waiting for a start event
    // ISSUE    | command presented, waiting for cmd_ready
    // WAIT_RSP | command accepted, waiting for ACK/NACK
    // FINISH   | one-cycle done pulse, indicators updated
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, FINISH} state_t;

    localparam logic [3:0] LAST_IDX    = 4'(SEQ_LEN - 1);
    localparam logic [3:0] RETRY_LIMIT = (MAX_RETRY > 14) ? 4'd14 : 4'(MAX_RETRY);
`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    state_t                   state_q;
    logic [8*(SEQ_LEN-1)-1:0] cap_q;
    logic [3:0]               idx_q;
    logic [3:0]               attempt_q;
    logic [3:0]               ack_q;

    logic       sync_1, sync_2, sync_2_d;
    logic [2:0] settle;
    logic       start_evt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // settle[2] marks sync_2_d as holding a real sample, so a button held
    // through reset release cannot look like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_2_d  <= 1'b1;
            settle    <= 3'b000;
            start_evt <= 1'b0;
        end else begin
            sync_1    <= start_bar;
            sync_2    <= sync_1;
            sync_2_d  <= sync_2;
            settle    <= {settle[1:0], 1'b1};
            start_evt <= settle[2] & sync_2_d & ~sync_2;
        end
    end

    assign display = {attempt_q, ack_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q                    <= IDLE;
            cap_q                      <= '0;
            idx_q                      <= 4'd0;
            attempt_q                  <= 4'd0;
            ack_q                      <= 4'd0;
            cmd_valid                  <= 1'b0;
            cmd_data                   <= 8'h00;
            cmd_start                  <= 1'b0;
            cmd_stop                   <= 1'b0;
            busy                       <= 1'b0;
            done                       <= 1'b0;
            indicate_ack_received_bar  <= 1'b1;
            indicate_nack_received_bar <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start_evt) begin
                        cap_q     <= payload;
                        idx_q     <= 4'd0;
                        attempt_q <= 4'd1;
                        ack_q     <= 4'd0;
                        busy      <= 1'b1;
                        cmd_valid <= 1'b1;
                        cmd_data  <= {DEV_ADDR, 1'b0};
                        cmd_start <= 1'b1;
                        cmd_stop  <= 1'b0;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_start <= 1'b0;
                        cmd_stop  <= 1'b0;
                        state_q   <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_valid && !rsp_nack) begin
                        ack_q <= sat_inc(ack_q);
                        if (idx_q == LAST_IDX) begin
                            done                       <= 1'b1;
                            indicate_ack_received_bar  <= 1'b0;
                            indicate_nack_received_bar <= 1'b1;
                            state_q                    <= FINISH;
                        end else begin
                            // payload byte k lives at bit 8*(k-1); k = idx_q + 1
                            idx_q     <= idx_q + 4'd1;
                            cmd_valid <= 1'b1;
                            cmd_data  <= cap_q[8*int'(idx_q) +: 8];
                            cmd_start <= 1'b0;
                            cmd_stop  <= ((idx_q + 4'd1) == LAST_IDX);
                            state_q   <= ISSUE;
                        end
                    end else if (rsp_valid && rsp_nack) begin
                        if (RETRY_EN && (attempt_q <= RETRY_LIMIT)) begin
                            attempt_q <= sat_inc(attempt_q);
                            idx_q     <= 4'd0;
                            ack_q     <= 4'd0;
                            cmd_valid <= 1'b1;
                            cmd_data  <= {DEV_ADDR, 1'b0};
                            cmd_start <= 1'b1;
                            cmd_stop  <= 1'b0;
                            state_q   <= ISSUE;
                        end else begin
                            // controller issues STOP itself after a NACK
                            done                       <= 1'b1;
                            indicate_ack_received_bar  <= 1'b1;
                            indicate_nack_received_bar <= 1'b0;
                            state_q                    <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Randomised bench for i2c_write_sequencer: the bench plays the I2C controller and
// compares commands, done pulses and indicators against a transaction-level model.
module tb_i2c_write_sequencer;
    localparam int         SEQ_LEN   = 3;
    localparam logic [6:0] DEV_ADDR  = 7'h50;
    localparam int         MAX_RETRY = 3;
    localparam int         PW        = 8*(SEQ_LEN-1);
`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_bar = 1'b1;
    logic [PW-1:0] payload = '0;
    logic          cmd_valid, cmd_start, cmd_stop, busy, done;
    logic          cmd_ready = 1'b0;
    logic [7:0]    cmd_data, display;
    logic          rsp_valid = 1'b0;
    logic          rsp_nack = 1'b0;
    logic          ack_bar, nack_bar;

    i2c_write_sequencer #(.SEQ_LEN(SEQ_LEN), .DEV_ADDR(DEV_ADDR), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset), .start_bar(start_bar), .payload(payload),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
        .busy(busy), .done(done),
        .indicate_ack_received_bar(ack_bar), .indicate_nack_received_bar(nack_bar),
        .display(display)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {logic [7:0] d; logic s; logic p;} cmd_t;
    cmd_t       exp_q[$];
    logic       rsp_q[$];
    logic       exp_ok;
    logic [7:0] exp_disp;
    int         nack_at[16];   // per attempt: byte index that NACKs, SEQ_LEN = none

    // Transaction model: expand attempts into the command list and responses.
    task automatic build_model(input logic [PW-1:0] pl);
        int   att, acks;
        logic hit;
        cmd_t c;
        exp_q.delete();
        rsp_q.delete();
        att = 0;
        acks = 0;
        do begin
            att++;
            acks = 0;
            hit = 1'b0;
            for (int k = 0; k < SEQ_LEN; k++) begin
                if (k == 0) c.d = {DEV_ADDR, 1'b0};
                else        c.d = pl[8*(k-1) +: 8];
                c.s = (k == 0);
                c.p = (k == SEQ_LEN-1);
                exp_q.push_back(c);
                hit = (k == nack_at[att-1]);
                rsp_q.push_back(hit);
                if (hit) break;
                acks++;
            end
        end while (hit && RETRY_EN && att <= MAX_RETRY);
        exp_ok   = !hit;
        exp_disp = {4'(att), 4'(acks)};
    endtask

    task automatic run_txn(input logic [PW-1:0] pl, input int hold, input bit press2);
        int         cyc, n_cmd, post, rwait;
        bit         pend, rbit, finished, first_v, prev_v, prev_r, bad_post;
        logic [9:0] prev_b;
        cyc = 0; n_cmd = 0; post = 0; rwait = 0;
        pend = 0; rbit = 0; finished = 0; first_v = 0; prev_v = 0; prev_r = 0; bad_post = 0;
        prev_b = '0;
        payload = pl;
        build_model(pl);
        @(negedge clk);
        start_bar = 1'b0;
        while (cyc < 300 && !(finished && post >= 8)) begin
            @(negedge clk);
            cyc++;
            if (prev_v && !prev_r)
                chk("hold", 32'({cmd_valid, cmd_data, cmd_start, cmd_stop}), 32'({1'b1, prev_b}));
            if (cmd_valid && !first_v) begin
                first_v = 1;
                chk("start_lat", cyc, 4);
            end
            if (finished) begin
                post++;
                if (cmd_valid || busy || done) bad_post = 1;
            end else if (done) begin
                finished = 1;
                chk("ack_bar", 32'(ack_bar), 32'(!exp_ok));
                chk("nack_bar", 32'(nack_bar), 32'(exp_ok));
                chk("display", 32'(display), 32'(exp_disp));
            end
            if (cyc == 5) start_bar = 1'b1;
            if (press2 && cyc == 7) start_bar = 1'b0;
            if (press2 && cyc == 10) start_bar = 1'b1;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            if (pend) begin
                if (rwait == 0) begin
                    rsp_valid = 1'b1;
                    rsp_nack  = rbit;
                    pend = 0;
                end else rwait--;
            end
            cmd_ready = (cyc >= 4 + hold) && ($urandom_range(0, 2) != 0);
            if (cmd_valid && cmd_ready) begin
                if (n_cmd < exp_q.size())
                    chk($sformatf("cmd%0d", n_cmd), 32'({cmd_data, cmd_start, cmd_stop}), 32'(exp_q[n_cmd]));
                rbit  = (n_cmd < rsp_q.size()) ? rsp_q[n_cmd] : 1'b0;
                n_cmd++;
                pend  = 1;
                rwait = $urandom_range(0, 3);
            end
            prev_v = cmd_valid;
            prev_r = cmd_ready;
            prev_b = {cmd_data, cmd_start, cmd_stop};
        end
        chk("done_seen", 32'(finished), 32'd1);
        chk("n_cmd", n_cmd, exp_q.size());
        chk("post_idle", 32'(bad_post), 32'd0);
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        start_bar = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_nack_all(input int v);
        for (int a = 0; a < 16; a++) nack_at[a] = v;
    endtask

    task automatic reset_mid_txn();
        bit seen, bad;
        seen = 0;
        bad  = 0;
        payload = PW'($urandom);
        @(negedge clk);
        start_bar = 1'b0;
        cmd_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1;
        end
        chk("rst_txn_started", 32'(seen), 32'd1);
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("rst_in_wait", 32'({busy, cmd_valid}), 32'(2'b10));
        #2 reset = 1'b1;
        #1 chk("rst_async", 32'({cmd_valid, cmd_start, cmd_stop, busy, done, cmd_data, ack_bar, nack_bar, display}),
               32'({5'b0, 8'h00, 2'b11, 8'h00}));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cmd_valid || busy || done) bad = 1;
        end
        chk("no_start_after_rst", 32'(bad), 32'd0);
        start_bar = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_vals", 32'({cmd_valid, cmd_start, cmd_stop, busy, done, cmd_data, ack_bar, nack_bar, display}),
            32'({5'b0, 8'h00, 2'b11, 8'h00}));
        reset = 1'b0;
        repeat (6) @(negedge clk);

        set_nack_all(SEQ_LEN);
        run_txn(16'hA55A, 0, 0);
        chk("all_ack_display", 32'(display), 32'h13);

        set_nack_all(1);
        run_txn(PW'($urandom), 0, 0);

        set_nack_all(0);
        run_txn(PW'($urandom), 0, 0);

        set_nack_all(SEQ_LEN);
        run_txn(PW'($urandom), 10, 1);

        reset_mid_txn();

        for (int t = 0; t < 20; t++) begin
            for (int a = 0; a < 16; a++)
                nack_at[a] = ($urandom_range(0, 1) != 0) ? SEQ_LEN : int'($urandom_range(0, SEQ_LEN-1));
            run_txn(PW'($urandom), int'($urandom_range(0, 3)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
